// File: rtl/pipe_stall_regs.sv
// pipe_stall_regs: IF/ID and ID/EX pipeline registers steered by the hazard unit's
// stall enables, with bubble insertion, a stall-duration FSM and saturating stall counters.
module pipe_stall_regs #(
    parameter int CTRL_W    = 8,
    parameter int MAX_STALL = 15,
    parameter int CNT_W     = 4,
    parameter int PERF_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_en,
    input  logic              ifid_en,
    input  logic              idex_en,
    input  logic              flush,
    input  logic [15:0]       if_pc,
    input  logic [15:0]       if_instr,
    input  logic [2:0]        id_rs,
    input  logic [2:0]        id_rt,
    input  logic [2:0]        id_dst,
    input  logic [CTRL_W-1:0] id_ctrl,
    output logic              pc_we,
    output logic [15:0]       ifid_pc,
    output logic [15:0]       ifid_instr,
    output logic              ifid_valid,
    output logic [2:0]        idex_rs,
    output logic [2:0]        idex_rt,
    output logic [2:0]        idex_dst,
    output logic [CTRL_W-1:0] idex_ctrl,
    output logic              idex_valid,
    output logic              stall_active,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic              stall_timeout,
    output logic [PERF_W-1:0] perf_stalls
);

    typedef enum logic [1:0] {RUN, STALL, STALL_TO} state_t;

    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_STALL);
    localparam logic [PERF_W-1:0] PERF_MAX = '1;

    state_t              state_q, state_d;
    logic [15:0]         ifid_pc_q, ifid_pc_d;
    logic [15:0]         ifid_instr_q, ifid_instr_d;
    logic                ifid_valid_q, ifid_valid_d;
    logic [2:0]          idex_rs_q, idex_rs_d;
    logic [2:0]          idex_rt_q, idex_rt_d;
    logic [2:0]          idex_dst_q, idex_dst_d;
    logic [CTRL_W-1:0]   idex_ctrl_q, idex_ctrl_d;
    logic                idex_valid_q, idex_valid_d;
    logic                stall_active_q, stall_active_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic                stall_timeout_q, stall_timeout_d;
    logic [PERF_W-1:0]   perf_stalls_q, perf_stalls_d;
    logic                stall;
    logic                bubble;
    logic [CNT_W-1:0]    cnt_inc;

    assign stall   = ~(pc_en & ifid_en & idex_en) & ~flush;
    // A held front end with an advancing back end must not re-issue the held instruction.
    assign bubble  = flush | (idex_en & ~ifid_en);
    assign cnt_inc = (stall_cnt_q >= CNT_MAX) ? CNT_MAX : stall_cnt_q + 1'b1;
    assign pc_we   = pc_en | flush;

    always_comb begin
        ifid_pc_d    = (!flush && ifid_en) ? if_pc : ifid_pc_q;
        ifid_instr_d = flush ? '0 : ifid_en ? if_instr : ifid_instr_q;
        ifid_valid_d = flush ? 1'b0 : ifid_en ? 1'b1 : ifid_valid_q;
        idex_rs_d    = bubble ? '0 : idex_en ? id_rs : idex_rs_q;
        idex_rt_d    = bubble ? '0 : idex_en ? id_rt : idex_rt_q;
        idex_dst_d   = bubble ? '0 : idex_en ? id_dst : idex_dst_q;
        idex_ctrl_d  = bubble ? '0 : idex_en ? id_ctrl : idex_ctrl_q;
        idex_valid_d = bubble ? 1'b0 : idex_en ? ifid_valid_q : idex_valid_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_pc_q    <= '0;
            ifid_instr_q <= '0;
            ifid_valid_q <= 1'b0;
            idex_rs_q    <= '0;
            idex_rt_q    <= '0;
            idex_dst_q   <= '0;
            idex_ctrl_q  <= '0;
            idex_valid_q <= 1'b0;
        end else begin
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            idex_rs_q    <= idex_rs_d;
            idex_rt_q    <= idex_rt_d;
            idex_dst_q   <= idex_dst_d;
            idex_ctrl_q  <= idex_ctrl_d;
            idex_valid_q <= idex_valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= RUN;
            stall_active_q  <= 1'b0;
            stall_cnt_q     <= '0;
            stall_timeout_q <= 1'b0;
            perf_stalls_q   <= '0;
        end else begin
            state_q         <= state_d;
            stall_active_q  <= stall_active_d;
            stall_cnt_q     <= stall_cnt_d;
            stall_timeout_q <= stall_timeout_d;
            perf_stalls_q   <= perf_stalls_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      state_d = !stall ? RUN : (cnt_inc == CNT_MAX) ? STALL_TO : STALL;
            STALL:    state_d = !stall ? RUN : (cnt_inc == CNT_MAX) ? STALL_TO : STALL;
            STALL_TO: state_d = stall ? STALL_TO : RUN;
            default:  state_d = RUN;
        endcase
    end

    // cnt_inc saturates, so STALL_TO naturally holds the count at MAX_STALL.
    always_comb begin
        stall_active_d  = (state_d != RUN);
        stall_cnt_d     = (state_d == RUN) ? '0 : cnt_inc;
        stall_timeout_d = stall_timeout_q | (state_d == STALL_TO);
        perf_stalls_d   = (stall && perf_stalls_q != PERF_MAX) ? perf_stalls_q + 1'b1 : perf_stalls_q;
    end

    assign ifid_pc       = ifid_pc_q;
    assign ifid_instr    = ifid_instr_q;
    assign ifid_valid    = ifid_valid_q;
    assign idex_rs       = idex_rs_q;
    assign idex_rt       = idex_rt_q;
    assign idex_dst      = idex_dst_q;
    assign idex_ctrl     = idex_ctrl_q;
    assign idex_valid    = idex_valid_q;
    assign stall_active  = stall_active_q;
    assign stall_cnt     = stall_cnt_q;
    assign stall_timeout = stall_timeout_q;
    assign perf_stalls   = perf_stalls_q;

endmodule

// File: doc/pipe_stall_regs.md
Name: pipe_stall_regs

Overview:
- Consumer side of the stall-enable interface. Takes the level-sensitive stall enables (pc_en, ifid_en, idex_en) and a branch flush, and applies them to the IF/ID and ID/EX pipeline registers of the 8-register, 16-bit MIPS core.
- Inserts bubbles when the front end is held and the back end advances.
- Tracks stall duration with an FSM and counters, and flags runaway stalls.

Parameters:
- CTRL_W, 8, width of the decoded control bundle carried ID->EX.
- MAX_STALL, 15, consecutive stall cycles before stall_timeout is raised.
- CNT_W, 4, width of the consecutive-stall counter; must hold MAX_STALL.
- PERF_W, 16, width of the total-stall performance counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- pc_en  in  1  PC advance enable from hazard detection.
- ifid_en  in  1  IF/ID load enable from hazard detection.
- idex_en  in  1  ID/EX load enable from hazard detection.
- flush  in  1  branch/jump taken; kills IF/ID and ID/EX contents.
- if_pc  in  16  PC of the fetched instruction.
- if_instr  in  16  fetched instruction word.
- id_rs, id_rt, id_dst  in  3 each  decoded register fields.
- id_ctrl  in  CTRL_W  decoded control bundle.
- pc_we  out  1  PC register write enable.
- ifid_pc, ifid_instr  out  16 each  IF/ID register contents.
- ifid_valid  out  1  IF/ID holds a live instruction.
- idex_rs, idex_rt, idex_dst  out  3 each  ID/EX register fields.
- idex_ctrl  out  CTRL_W  ID/EX control bundle; all-zero means a bubble.
- idex_valid  out  1  ID/EX holds a live instruction.
- stall_active  out  1  FSM is in STALL or STALL_TO.
- stall_cnt  out  CNT_W  consecutive stall cycles, saturating at MAX_STALL.
- stall_timeout  out  1  sticky runaway-stall flag.
- perf_stalls  out  PERF_W  total stall cycles since reset, saturating.

Behaviour:
- Reset (rst_n low, asynchronous): every register output is 0, including ifid_instr = 16'h0000 (NOP), ifid_valid = 0, idex_valid = 0, idex_ctrl = 0, stall_cnt = 0, stall_timeout = 0 and perf_stalls = 0. FSM goes to RUN.
- pc_we is combinational: pc_we = pc_en | flush. A flush always lets the PC take the branch target.
- A stall cycle is any cycle where (pc_en & ifid_en & idex_en) == 0 and flush = 0.
- IF/ID update, priority order, on the clock edge:
  - flush: ifid_valid <= 0, ifid_instr <= 0; ifid_pc is held.
  - else ifid_en = 1: load if_pc and if_instr, ifid_valid <= 1.
  - else: hold.
- ID/EX update, priority order, on the clock edge:
  - flush: bubble, i.e. idex_valid <= 0, idex_ctrl <= 0; register fields <= 0.
  - else idex_en = 1 and ifid_en = 0: bubble.
  - else idex_en = 1: load id_*, and idex_valid <= ifid_valid.
  - else: hold all ID/EX fields.
- Latency: one clock from input to register output; no combinational path from id_* or if_* to any output.
- FSM states and transitions:
  - RUN: a stall cycle moves to STALL with stall_cnt <= 1. Otherwise stall_cnt <= 0.
  - STALL: a stall cycle increments stall_cnt. When stall_cnt reaches MAX_STALL, move to STALL_TO and set stall_timeout <= 1. A non-stall cycle or flush returns to RUN with stall_cnt <= 0.
  - STALL_TO: stall_cnt holds at MAX_STALL. A non-stall cycle or flush returns to RUN with stall_cnt <= 0.
  - stall_timeout stays 1 until reset.
- perf_stalls increments on every stall cycle, saturates at all-ones and never wraps.
- stall_active is registered and reflects the current FSM state.
- Simultaneous events: flush overrides all enables for both registers and for the FSM, and the cycle does not count as a stall. Stall enables and register loads are sampled on the same edge.
- Mid-operation reset: all state clears immediately and asynchronously. On the first edge after rst_n rises, normal loads resume.
- Enables that are X or Z are illegal. The bench asserts against them.

Test Plan:
- Reset with all enables 1, then feed if_instr = 16'h1234 at if_pc = 16'h0010 and id_ctrl = 8'hA5 -> after edge 1: ifid_instr = 16'h1234, ifid_valid = 1. After edge 2: idex_ctrl = 8'hA5, idex_valid = 1. stall_cnt stays 0.
- Drop pc_en = ifid_en = 0 with idex_en = 1 for 3 cycles -> pc_we = 0; IF/ID holds 16'h1234; idex_ctrl = 0 and idex_valid = 0 (bubble); stall_cnt runs 1, 2, 3; perf_stalls = 3. Re-enabling returns to RUN with stall_cnt = 0.
- All three enables 0 for 2 cycles -> both registers hold their values exactly, stall_active = 1, perf_stalls advances by 2.
- Hold the stall for 20 cycles with MAX_STALL = 15 -> stall_timeout rises on the 15th stall edge, stall_cnt saturates at 15. After release stall_timeout remains 1 until rst_n pulses low.
- Assert flush together with ifid_en = 0 and idex_en = 0 -> pc_we = 1; ifid_valid = 0 and idex_valid = 0 on the next edge; FSM goes to RUN; perf_stalls is unchanged.
- Pulse rst_n low between clock edges mid-stall (stall_cnt = 5) -> all outputs go to 0 immediately without waiting for a clock edge.
